// File: rtl/ten_eth_tx_arbiter.sv
// Packet-granular arbiter sharing the 10G Ethernet TX AXI-Stream input among
// P_CH_NUM requesters, with optional strict priority for channel 0.
module ten_eth_tx_arbiter #(
  parameter int unsigned P_CH_NUM     = 4,
  parameter int unsigned P_DATA_WIDTH = 64,
  parameter int unsigned P_KEEP_WIDTH = 8,
  parameter int unsigned P_CH0_PRIO   = 1
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic                             i_tx_en,
  input  logic [P_CH_NUM*P_DATA_WIDTH-1:0] s_axis_data,
  input  logic [P_CH_NUM*P_KEEP_WIDTH-1:0] s_axis_keep,
  input  logic [P_CH_NUM-1:0]              s_axis_last,
  input  logic [P_CH_NUM-1:0]              s_axis_valid,
  output logic [P_CH_NUM-1:0]              s_axis_ready,
  output logic [P_DATA_WIDTH-1:0]          m_axis_data,
  output logic [P_KEEP_WIDTH-1:0]          m_axis_keep,
  output logic                             m_axis_last,
  output logic                             m_axis_valid,
  input  logic                             m_axis_ready,
  output logic [P_CH_NUM-1:0]              o_grant,
  output logic                             o_busy
);

  localparam int unsigned PTR_W = $clog2(P_CH_NUM);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_XMIT = 1'b1
  } state_t;

  state_t                state_q;
  state_t                state_d;
  logic [P_CH_NUM-1:0]   grant_q;
  logic [P_CH_NUM-1:0]   grant_d;
  logic [PTR_W-1:0]      grant_idx_q;
  logic [PTR_W-1:0]      grant_idx_d;
  logic [PTR_W-1:0]      rr_ptr_q;
  logic [PTR_W-1:0]      rr_ptr_d;
  logic                  busy_q;
  logic                  busy_d;

  logic                  win_found;
  logic [PTR_W-1:0]      win_idx;
  int unsigned           rr_sum;
  logic                  eop_xfer;

  assign o_grant  = grant_q;
  assign o_busy   = busy_q;
  assign eop_xfer = m_axis_valid & m_axis_ready & m_axis_last;

  // State register; reset drops the owner so pass-through outputs clear at once
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q     <= ST_IDLE;
      grant_q     <= '0;
      grant_idx_q <= '0;
      rr_ptr_q    <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      grant_idx_q <= grant_idx_d;
      rr_ptr_q    <= rr_ptr_d;
      busy_q      <= busy_d;
    end
  end

  // Winner search: channel 0 first when prioritised, else rr_ptr, rr_ptr+1, ... wrapping
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    rr_sum    = 0;
    if ((P_CH0_PRIO != 0) && s_axis_valid[0]) begin
      win_found = 1'b1;
    end else begin
      for (int unsigned i = 0; i < P_CH_NUM; i++) begin
        rr_sum = 32'(rr_ptr_q) + i;
        if (rr_sum >= P_CH_NUM) begin
          rr_sum = rr_sum - P_CH_NUM;
        end
        if (!win_found && s_axis_valid[PTR_W'(rr_sum)]) begin
          win_found = 1'b1;
          win_idx   = PTR_W'(rr_sum);
        end
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    grant_idx_d = grant_idx_q;
    rr_ptr_d    = rr_ptr_q;
    busy_d      = busy_q;
    case (state_q)
      ST_IDLE: begin
        if (i_tx_en && win_found) begin
          state_d     = ST_XMIT;
          grant_d     = P_CH_NUM'(1) << win_idx;
          grant_idx_d = win_idx;
          busy_d      = 1'b1;
        end
      end
      ST_XMIT: begin
        if (eop_xfer) begin
          state_d = ST_IDLE;
          grant_d = '0;
          busy_d  = 1'b0;
          // A prioritised channel 0 does not take a round-robin turn
          if (!((P_CH0_PRIO != 0) && (grant_idx_q == '0))) begin
            if (grant_idx_q == PTR_W'(P_CH_NUM - 1)) begin
              rr_ptr_d = '0;
            end else begin
              rr_ptr_d = PTR_W'(grant_idx_q + 1'b1);
            end
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Combinational pass-through of the owning channel while transmitting
  always_comb begin
    m_axis_data  = '0;
    m_axis_keep  = '0;
    m_axis_last  = 1'b0;
    m_axis_valid = 1'b0;
    s_axis_ready = '0;
    if (state_q == ST_XMIT) begin
      m_axis_data  = s_axis_data[32'(grant_idx_q)*P_DATA_WIDTH +: P_DATA_WIDTH];
      m_axis_keep  = s_axis_keep[32'(grant_idx_q)*P_KEEP_WIDTH +: P_KEEP_WIDTH];
      m_axis_last  = s_axis_last[grant_idx_q];
      m_axis_valid = s_axis_valid[grant_idx_q];
      s_axis_ready[grant_idx_q] = m_axis_ready;
    end
  end

endmodule

// File: tb/tb_ten_eth_tx_arbiter.sv
// Self-checking bench for ten_eth_tx_arbiter: vector table, directed packet
// sequences and randomized traffic against a cycle-level behavioural model.
module tb_ten_eth_tx_arbiter;

  localparam int unsigned N    = 4;
  localparam int unsigned W    = 64;
  localparam int unsigned K    = 8;
  localparam int unsigned PRIO = 1;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           tx_en;
  logic [N*W-1:0] s_data;
  logic [N*K-1:0] s_keep;
  logic [N-1:0]   s_last;
  logic [N-1:0]   s_valid;
  logic [N-1:0]   s_ready;
  logic [W-1:0]   m_data;
  logic [K-1:0]   m_keep;
  logic           m_last;
  logic           m_valid;
  logic           m_ready;
  logic [N-1:0]   grant;
  logic           busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ten_eth_tx_arbiter #(
    .P_CH_NUM    (N),
    .P_DATA_WIDTH(W),
    .P_KEEP_WIDTH(K),
    .P_CH0_PRIO  (PRIO)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst_n),
    .i_tx_en      (tx_en),
    .s_axis_data  (s_data),
    .s_axis_keep  (s_keep),
    .s_axis_last  (s_last),
    .s_axis_valid (s_valid),
    .s_axis_ready (s_ready),
    .m_axis_data  (m_data),
    .m_axis_keep  (m_keep),
    .m_axis_last  (m_last),
    .m_axis_valid (m_valid),
    .m_axis_ready (m_ready),
    .o_grant      (grant),
    .o_busy       (busy)
  );

  // Behavioural model: current owner (-1 = none) and round-robin start point
  int mdl_owner = -1;
  int mdl_rr    = 0;

  // Packet sources
  int         src_len  [N];
  int         src_beat [N];
  int         src_pid  [N];
  logic [K-1:0] src_lkeep[N];
  bit         auto_rs  [N];
  bit         gappy;

  // Observed output packets
  int         pkt_ch[$];
  int         pkt_len[$];
  logic [K-1:0] pkt_keep[$];
  int         cur_beats;
  int         hs_cnt;

  typedef struct {
    logic         rst_n;
    logic         tx_en;
    logic         m_ready;
    logic [N-1:0] valid;
    logic [N-1:0] last;
    logic [N-1:0] e_grant;
    logic         e_busy;
    logic [N-1:0] e_ready;
    logic         e_valid;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(logic r, logic en, logic mr, logic [N-1:0] v, logic [N-1:0] l,
                              logic [N-1:0] eg, logic eb, logic [N-1:0] er, logic ev);
    vec_t x;
    x.rst_n = r; x.tx_en = en; x.m_ready = mr; x.valid = v; x.last = l;
    x.e_grant = eg; x.e_busy = eb; x.e_ready = er; x.e_valid = ev;
    vecs.push_back(x);
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  function automatic int pick(logic [N-1:0] v, int rr);
    if (PRIO != 0 && v[0]) return 0;
    for (int i = 0; i < int'(N); i++) begin
      if (v[(rr + i) % N]) return (rr + i) % N;
    end
    return -1;
  endfunction

  task automatic start_pkt(int k, int len, logic [K-1:0] lkeep);
    src_len[k]   = len;
    src_beat[k]  = 0;
    src_lkeep[k] = lkeep;
    src_pid[k]   = src_pid[k] + 1;
  endtask

  task automatic drive_inputs();
    for (int k = 0; k < int'(N); k++) begin
      logic act;
      logic lst;
      act = (src_len[k] != 0);
      lst = act && (src_beat[k] == src_len[k] - 1);
      s_valid[k] = act && (!gappy || ($urandom_range(3) != 0));
      s_last[k]  = lst;
      s_data[k*W +: W] = {8'(k), 24'(src_pid[k]), 32'(src_beat[k])};
      s_keep[k*K +: K] = lst ? src_lkeep[k] : {K{1'b1}};
    end
  endtask

  // Compare the DUT against the model for this cycle, then advance the model
  task automatic check_model();
    logic [N-1:0] e_grant, e_ready;
    logic         e_busy, e_valid, e_last;
    logic [W-1:0] e_data;
    logic [K-1:0] e_keep;
    bit           bad;
    e_grant = '0; e_ready = '0; e_busy = 1'b0; e_valid = 1'b0;
    e_last = 1'b0; e_data = '0; e_keep = '0;
    if (!rst_n) begin
      mdl_owner = -1;
      mdl_rr    = 0;
    end else if (mdl_owner < 0) begin
      if (tx_en && (s_valid != '0)) mdl_owner = pick(s_valid, mdl_rr);
    end else begin
      int g;
      g = mdl_owner;
      e_grant[g] = 1'b1;
      e_busy     = 1'b1;
      e_ready[g] = m_ready;
      e_valid    = s_valid[g];
      e_last     = s_last[g];
      e_data     = s_data[g*W +: W];
      e_keep     = s_keep[g*K +: K];
      if (e_valid && m_ready && e_last) begin
        mdl_owner = -1;
        if (!(g == 0 && PRIO != 0)) mdl_rr = (g + 1) % N;
      end
    end
    bad = (grant !== e_grant) || (busy !== e_busy) || (s_ready !== e_ready) ||
          (m_valid !== e_valid) ||
          (e_valid && ((m_data !== e_data) || (m_keep !== e_keep) || (m_last !== e_last)));
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL model t=%0t: grant=%b busy=%b rdy=%b mv=%b md=%h mk=%h ml=%b | want grant=%b busy=%b rdy=%b mv=%b md=%h mk=%h ml=%b",
               $time, grant, busy, s_ready, m_valid, m_data, m_keep, m_last,
               e_grant, e_busy, e_ready, e_valid, e_data, e_keep, e_last);
    end
  endtask

  task automatic advance();
    if (rst_n && m_valid && m_ready) begin
      hs_cnt++;
      cur_beats++;
      if (m_last) begin
        int ch;
        ch = -1;
        for (int k = 0; k < int'(N); k++) if (grant[k]) ch = k;
        pkt_ch.push_back(ch);
        pkt_len.push_back(cur_beats);
        pkt_keep.push_back(m_keep);
        cur_beats = 0;
      end
    end
    if (!rst_n) begin
      cur_beats = 0;
      for (int k = 0; k < int'(N); k++) src_len[k] = 0;
    end else begin
      for (int k = 0; k < int'(N); k++) begin
        if (s_valid[k] && s_ready[k]) begin
          if (s_last[k]) begin
            if (auto_rs[k]) start_pkt(k, src_len[k], src_lkeep[k]);
            else src_len[k] = 0;
          end else begin
            src_beat[k]++;
          end
        end
      end
    end
  endtask

  task automatic tick();
    drive_inputs();
    #1;
    check_model();
    advance();
    @(negedge clk);
  endtask

  task automatic clear_obs();
    pkt_ch.delete();
    pkt_len.delete();
    pkt_keep.delete();
    hs_cnt = 0;
  endtask

  task automatic do_reset();
    for (int k = 0; k < int'(N); k++) auto_rs[k] = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    clear_obs();
  endtask

  task automatic run_pkts(int n, int budget, string name);
    int t;
    t = 0;
    while (pkt_ch.size() < n && t < budget) begin
      tick();
      t++;
    end
    checks++;
    if (pkt_ch.size() < n) begin
      errors++;
      $display("FAIL %s timeout: %0d of %0d packets", name, pkt_ch.size(), n);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b1; tx_en = 1'b0; m_ready = 1'b1;
    s_data = '0; s_keep = '0; s_last = '0; s_valid = '0;
    gappy = 1'b0; cur_beats = 0; hs_cnt = 0;
    for (int k = 0; k < int'(N); k++) begin
      src_len[k] = 0; src_beat[k] = 0; src_pid[k] = 0; src_lkeep[k] = '1; auto_rs[k] = 1'b0;
    end
    #1 rst_n = 1'b0;
    @(negedge clk);

    // ---- Vector table: rst, en, mr, valid, last -> grant, busy, ready, m_valid
    add(0, 0, 1, 4'b0000, 4'b0000, 4'b0000, 0, 4'b0000, 0);
    add(0, 0, 1, 4'b0000, 4'b0000, 4'b0000, 0, 4'b0000, 0);
    add(1, 1, 1, 4'b0000, 4'b0000, 4'b0000, 0, 4'b0000, 0);
    add(1, 0, 1, 4'b0010, 4'b0000, 4'b0000, 0, 4'b0000, 0);
    add(1, 0, 1, 4'b0010, 4'b0000, 4'b0000, 0, 4'b0000, 0);
    add(1, 1, 1, 4'b0010, 4'b0000, 4'b0000, 0, 4'b0000, 0);
    add(1, 0, 1, 4'b0010, 4'b0000, 4'b0010, 1, 4'b0010, 1);
    add(1, 0, 0, 4'b0010, 4'b0000, 4'b0010, 1, 4'b0000, 1);
    add(1, 0, 1, 4'b0000, 4'b0000, 4'b0010, 1, 4'b0010, 0);
    add(1, 0, 1, 4'b0010, 4'b0010, 4'b0010, 1, 4'b0010, 1);
    add(1, 1, 1, 4'b0011, 4'b0001, 4'b0000, 0, 4'b0000, 0);
    add(1, 1, 1, 4'b0011, 4'b0001, 4'b0001, 1, 4'b0001, 1);
    add(1, 1, 1, 4'b0110, 4'b0100, 4'b0000, 0, 4'b0000, 0);
    add(1, 1, 1, 4'b0110, 4'b0100, 4'b0100, 1, 4'b0100, 1);
    add(1, 1, 1, 4'b0010, 4'b0000, 4'b0000, 0, 4'b0000, 0);
    add(0, 1, 1, 4'b0010, 4'b0000, 4'b0000, 0, 4'b0000, 0);
    add(1, 1, 1, 4'b1010, 4'b0010, 4'b0000, 0, 4'b0000, 0);
    add(1, 1, 1, 4'b1010, 4'b0010, 4'b0010, 1, 4'b0010, 1);
    add(1, 1, 1, 4'b1000, 4'b1000, 4'b0000, 0, 4'b0000, 0);
    add(1, 1, 1, 4'b1000, 4'b1000, 4'b1000, 1, 4'b1000, 1);
    add(1, 1, 1, 4'b0110, 4'b0010, 4'b0000, 0, 4'b0000, 0);
    add(1, 1, 1, 4'b0110, 4'b0010, 4'b0010, 1, 4'b0010, 1);
    add(1, 1, 1, 4'b0000, 4'b0000, 4'b0000, 0, 4'b0000, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      logic [W-1:0] e_data;
      logic [K-1:0] e_keep;
      logic         e_last;
      rst_n = vecs[i].rst_n; tx_en = vecs[i].tx_en; m_ready = vecs[i].m_ready;
      s_valid = vecs[i].valid; s_last = vecs[i].last;
      for (int k = 0; k < int'(N); k++) begin
        s_data[k*W +: W] = {32'hD00D_0000 + 32'(k), 32'(i)};
        s_keep[k*K +: K] = K'(k + 1);
      end
      e_data = '0; e_keep = '0; e_last = 1'b0;
      for (int k = 0; k < int'(N); k++) begin
        if (vecs[i].e_grant[k]) begin
          e_data = {32'hD00D_0000 + 32'(k), 32'(i)};
          e_keep = K'(k + 1);
          e_last = vecs[i].last[k];
        end
      end
      #1;
      checks++;
      if (grant !== vecs[i].e_grant || busy !== vecs[i].e_busy || s_ready !== vecs[i].e_ready ||
          m_valid !== vecs[i].e_valid ||
          (vecs[i].e_valid && (m_data !== e_data || m_keep !== e_keep || m_last !== e_last))) begin
        errors++;
        $display("FAIL vec%0d: grant=%b busy=%b rdy=%b mv=%b md=%h | want grant=%b busy=%b rdy=%b mv=%b md=%h",
                 i, grant, busy, s_ready, m_valid, m_data,
                 vecs[i].e_grant, vecs[i].e_busy, vecs[i].e_ready, vecs[i].e_valid, e_data);
      end
      @(negedge clk);
    end

    // ---- Reset then idle
    tx_en = 1'b1; m_ready = 1'b1; gappy = 1'b0;
    rst_n = 1'b0;
    repeat (5) tick();
    rst_n = 1'b1;
    repeat (5) tick();
    chk("idle_grant", 64'(grant), 64'd0);
    chk("idle_busy", 64'(busy), 64'd0);

    // ---- Round-robin among channels 1..3 with back-to-back packets
    do_reset();
    for (int k = 1; k < 4; k++) begin
      auto_rs[k] = 1'b1;
      start_pkt(k, 3, 8'hFF);
    end
    run_pkts(6, 80, "rr");
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("rr_order%0d", i), 64'(pkt_ch[i]), 64'((i % 3) + 1));
      chk($sformatf("rr_len%0d", i), 64'(pkt_len[i]), 64'd3);
    end

    // ---- Channel 0 priority while channel 2 is mid-packet, channel 3 pending
    do_reset();
    start_pkt(2, 5, 8'hFF);
    start_pkt(3, 3, 8'h3F);
    tick();
    tick();
    start_pkt(0, 1, 8'h01);
    run_pkts(3, 60, "prio");
    chk("prio_ch0", 64'(pkt_ch[0]), 64'd2);
    chk("prio_ch1", 64'(pkt_ch[1]), 64'd0);
    chk("prio_ch2", 64'(pkt_ch[2]), 64'd3);
    chk("prio_len0", 64'(pkt_len[0]), 64'd5);
    chk("prio_len1", 64'(pkt_len[1]), 64'd1);
    chk("prio_len2", 64'(pkt_len[2]), 64'd3);

    // ---- Slot gating
    do_reset();
    tx_en = 1'b0;
    start_pkt(1, 4, 8'hFF);
    repeat (20) tick();
    chk("gate_grant", 64'(grant), 64'd0);
    chk("gate_hs", 64'(hs_cnt), 64'd0);
    tx_en = 1'b1;
    tick();
    chk("gate_grant_next", 64'(grant), 64'b0010);
    tick();
    tx_en = 1'b0;
    run_pkts(1, 20, "gate");
    chk("gate_len", 64'(pkt_len[0]), 64'd4);
    tx_en = 1'b1;

    // ---- Backpressure pattern during an 8-beat packet
    do_reset();
    start_pkt(2, 8, 8'h0F);
    tick();
    start_pkt(1, 2, 8'hFF);
    start_pkt(3, 2, 8'hFF);
    begin
      int t;
      t = 0;
      while (pkt_ch.size() < 1 && t < 100) begin
        m_ready = (t % 3 == 0);
        tick();
        t++;
      end
      chk("bp_done", 64'(pkt_ch.size() >= 1), 64'd1);
    end
    m_ready = 1'b1;
    chk("bp_ch", 64'(pkt_ch[0]), 64'd2);
    chk("bp_len", 64'(pkt_len[0]), 64'd8);
    chk("bp_keep", 64'(pkt_keep[0]), 64'h0F);
    run_pkts(3, 30, "bp_drain");

    // ---- Mid-packet reset
    do_reset();
    start_pkt(1, 2, 8'hFF);
    run_pkts(1, 20, "pre_rst");
    start_pkt(2, 6, 8'hFF);
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("rst_mvalid", 64'(m_valid), 64'd0);
    chk("rst_grant", 64'(grant), 64'd0);
    tick();
    rst_n = 1'b1;
    clear_obs();
    for (int k = 1; k < 4; k++) start_pkt(k, 2, 8'hFF);
    tick();
    chk("rst_regrant", 64'(grant), 64'b0010);
    run_pkts(3, 30, "post_rst");

    // ---- Randomized traffic against the model
    do_reset();
    gappy = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      tx_en   = ($urandom_range(7) != 0);
      m_ready = ($urandom_range(3) != 0);
      rst_n   = ($urandom_range(599) != 0);
      for (int k = 0; k < int'(N); k++) begin
        if (src_len[k] == 0 && $urandom_range(5) == 0)
          start_pkt(k, int'($urandom_range(6, 1)), K'($urandom_range(255, 1)));
      end
      tick();
    end
    rst_n = 1'b1;
    chk("rand_traffic", 64'(pkt_ch.size() > 100), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
